// File: rtl/ic_refill_streamer.sv
// ic_refill_streamer: L2-side responder for instruction-cache line refills.
// On a miss it latches the line base, reads the whole line from backing
// memory into a local buffer, then streams it to the cache as BEATS
// back-to-back 64-bit beats followed by a single cooldown cycle.
module ic_refill_streamer #(
  parameter int B      = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ic_miss_i,
  input  logic [ADDR_W-1:0] ic_miss_addr_i,
  output logic              ic_repl_grant_o,
  output logic [63:0]       rep_word_o,
  output logic              busy_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i
);

  localparam int BEATS = B / 8;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = BW + 1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM, COOLDOWN} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     issue_cnt, resp_cnt;
  logic [BW-1:0]     beat;
  logic [ADDR_W-1:0] base;
  logic [63:0]       line_buf [BEATS];
  logic              issue, take, last_resp;

  // Responses past the end of the line are dropped, so the buffer index
  // never leaves the line.
  assign issue     = mem_req_o && mem_ready_i;
  assign take      = (state == FILL) && mem_rvalid_i && (resp_cnt < CW'(BEATS));
  assign last_resp = take && (resp_cnt == CW'(BEATS - 1));

  // Next-state and output decode; every output defaults to its idle value.
  always_comb begin
    state_nxt       = state;
    ic_repl_grant_o = 1'b0;
    rep_word_o      = '0;
    busy_o          = (state != IDLE);
    mem_req_o       = 1'b0;
    mem_addr_o      = '0;
    case (state)
      IDLE: begin
        if (ic_miss_i) state_nxt = FILL;
      end
      FILL: begin
        mem_req_o = (issue_cnt < CW'(BEATS));
        if (mem_req_o) mem_addr_o = base + (ADDR_W'(issue_cnt) << 3);
        if (last_resp) state_nxt = STREAM;
      end
      STREAM: begin
        ic_repl_grant_o = 1'b1;
        rep_word_o      = line_buf[beat];
        if (beat == BW'(BEATS - 1)) state_nxt = COOLDOWN;
      end
      COOLDOWN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control state: FSM register and the issue/response/beat counters.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      issue_cnt <= '0;
      resp_cnt  <= '0;
      beat      <= '0;
    end else begin
      state <= state_nxt;
      if (state == FILL) begin
        if (issue) issue_cnt <= issue_cnt + CW'(1);
        if (take)  resp_cnt  <= resp_cnt + CW'(1);
      end else begin
        issue_cnt <= '0;
        resp_cnt  <= '0;
      end
      if (state == STREAM) beat <= beat + BW'(1);
      else                 beat <= '0;
    end
  end

  // Datapath: line base captured only while idle, buffer filled in response order.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && ic_miss_i) base <= ic_miss_addr_i & ~ADDR_W'(B - 1);
    if (take) line_buf[resp_cnt[BW-1:0]] <= mem_rdata_i;
  end

endmodule

// File: tb/tb_ic_refill_streamer.sv
// Randomized bench for ic_refill_streamer with a transaction-level reference
// model: each refill is tracked by its base, issue/response counts and the
// cycle of its last response, from which every output is predicted.
module tb_ic_refill_streamer;
  localparam int B      = 64;
  localparam int ADDR_W = 32;
  localparam int BEATS  = B / 8;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              ic_miss_i;
  logic [ADDR_W-1:0] ic_miss_addr_i;
  logic              ic_repl_grant_o;
  logic [63:0]       rep_word_o;
  logic              busy_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_ready_i;
  logic              mem_rvalid_i;
  logic [63:0]       mem_rdata_i;

  always #5 clk_i = ~clk_i;

  ic_refill_streamer #(.B(B), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .ic_miss_i      (ic_miss_i),
    .ic_miss_addr_i (ic_miss_addr_i),
    .ic_repl_grant_o(ic_repl_grant_o),
    .rep_word_o     (rep_word_o),
    .busy_o         (busy_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_ready_i    (mem_ready_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i)
  );

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  pend_t       pq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rdy_mode = 0;
  int          gap_max = 0;
  logic [31:0] salt = 32'h0;

  // Reference model of the refill in flight.
  bit          active = 0;
  bit          fill_done = 0;
  bit          exp_req = 0;
  logic [31:0] base_m = 32'h0;
  int          n_iss = 0;
  int          n_resp = 0;
  int          lr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Memory contents: plain address when salt is zero, otherwise a scrambled
  // upper half so beat-order errors show in both halves.
  function automatic logic [63:0] word_of(input logic [31:0] a);
    if (salt == 32'h0) return {32'h0, a};
    return {salt ^ (a * 32'h9E37_79B1), a};
  endfunction

  // One clock cycle: drive inputs, advance the model, then check outputs.
  task automatic step(input logic miss, input logic [31:0] addr, input logic rst);
    logic        rdy, rv;
    logic [63:0] rd;
    logic [63:0] e_word;
    logic [31:0] e_addr;
    bit          e_grant;
    pend_t       head;
    int          gap;
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = (cyc % 2 == 0);
      default: rdy = 1'($urandom_range(1, 0));
    endcase
    rv = 1'b0;
    rd = '0;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      head = pq.pop_front();
      rv   = 1'b1;
      rd   = word_of(head.a);
    end
    ic_miss_i      = miss;
    ic_miss_addr_i = addr;
    reset_i        = rst;
    mem_ready_i    = rdy;
    mem_rvalid_i   = rv;
    mem_rdata_i    = rd;
    if (rst) begin
      pq.delete();
      active    = 0;
      fill_done = 0;
    end else begin
      if (mem_req_o && rdy) begin
        gap = int'($urandom_range(gap_max, 0));
        pq.push_back('{a: mem_addr_o, due: cyc + 1 + gap});
      end
      if (active && !fill_done) begin
        if (exp_req && rdy) n_iss++;
        if (rv) begin
          n_resp++;
          if (n_resp == BEATS) begin
            fill_done = 1;
            lr        = cyc;
          end
        end
      end else if (!active && miss) begin
        active    = 1;
        fill_done = 0;
        base_m    = addr & ~32'(B - 1);
        n_iss     = 0;
        n_resp    = 0;
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
    // Stream occupies lr+1..lr+BEATS, cooldown lr+BEATS+1, idle afterwards.
    if (active && fill_done && cyc >= lr + BEATS + 2) active = 0;
    e_grant = 0;
    e_word  = '0;
    e_addr  = '0;
    exp_req = 0;
    if (active && !fill_done) begin
      exp_req = (n_iss < BEATS);
      if (exp_req) e_addr = base_m + 32'(8 * n_iss);
    end else if (active && cyc <= lr + BEATS) begin
      e_grant = 1;
      e_word  = word_of(base_m + 32'(8 * (cyc - lr - 1)));
    end
    check("busy",     {63'b0, busy_o},          {63'b0, active});
    check("grant",    {63'b0, ic_repl_grant_o}, {63'b0, e_grant});
    check("rep_word", rep_word_o,               e_word);
    check("mem_req",  {63'b0, mem_req_o},       {63'b0, exp_req});
    check("mem_addr", {32'b0, mem_addr_o},      {32'b0, e_addr});
  endtask

  // One refill from an idle DUT; junk 1 drops the miss and moves the address
  // to 0x8000, junk 2 drives random miss/address; rst_beat>0 resets on that
  // stream cycle.
  task automatic refill(input logic [31:0] addr, input int junk, input int rst_beat);
    int          n;
    logic        m, r;
    logic [31:0] a;
    step(1'b1, addr, 1'b0);
    n = 0;
    while (active && n < 300) begin
      m = 1'b0;
      a = 32'h0;
      if (junk == 1) a = 32'h8000;
      else if (junk == 2) begin
        m = 1'($urandom_range(1, 0));
        a = $urandom;
      end
      r = (rst_beat > 0 && fill_done && cyc == lr + rst_beat);
      step(m, a, r);
      n++;
    end
    check("timeout", {63'b0, active}, 64'd0);
  endtask

  initial begin
    int n;
    ic_miss_i      = 1'b0;
    ic_miss_addr_i = '0;
    reset_i        = 1'b1;
    mem_ready_i    = 1'b0;
    mem_rvalid_i   = 1'b0;
    mem_rdata_i    = '0;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Basic refill: always ready, 1-cycle latency, rdata = addr.
    refill(32'h0000_1234, 0, 0);

    // Toggling ready, random response gaps, scrambled data, random lines.
    rdy_mode = 1;
    gap_max  = 3;
    salt     = $urandom | 32'h1;
    refill(32'h0000_1234, 0, 0);
    rdy_mode = 2;
    repeat (4) refill($urandom, 0, 0);

    // Miss dropped / address changed while busy.
    refill(32'h0000_1234, 1, 0);
    refill(32'h0000_8000, 0, 0);
    refill($urandom, 2, 0);
    refill($urandom, 2, 0);

    // Reset on the 4th stream cycle, then a fresh refill.
    rdy_mode = 0;
    gap_max  = 0;
    salt     = 32'h0;
    refill(32'h0000_1234, 0, 4);
    refill(32'h0000_2468, 0, 0);
    rdy_mode = 2;
    gap_max  = 3;
    salt     = $urandom | 32'h1;
    refill($urandom, 0, 6);
    refill($urandom, 0, 0);

    // Miss held high: back-to-back refills.
    repeat (70) step(1'b1, 32'h0000_4448, 1'b0);
    n = 0;
    while (active && n < 300) begin
      step(1'b0, 32'h0, 1'b0);
      n++;
    end
    check("drain_timeout", {63'b0, active}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
